// File: rtl/skut_pkg.sv
// Shared SKUT definitions used by the frame former, the ping-pong controller and the DAC distributor.
package skut_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam logic [DATA_W-1:0] IDLE_CODE = 8'h80;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/skut_pingpong_ctrl.sv
// Ping-pong bank controller for the two SKUT frame buffers: bank swap, enable gating,
// DAC read mux with muting, and overrun/underrun detection.
module skut_pingpong_ctrl
    import skut_pkg::*;
#(
    parameter int                     DATA_W     = skut_pkg::DATA_W,
    parameter logic [DATA_W-1:0]      IDLE_CODE  = skut_pkg::IDLE_CODE,
    parameter int                     MUTE_AFTER = 4,
    parameter int                     CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_in,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    input  logic              rd_en_in,
    input  logic [DATA_W-1:0] buf0_q,
    input  logic [DATA_W-1:0] buf1_q,
    output logic              buf0_wren,
    output logic              buf1_wren,
    output logic              buf0_rden,
    output logic              buf1_rden,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic [DATA_W-1:0] dac_data,
    output logic              mute,
    output logic              overrun,
    output logic              underrun,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam logic [3:0] MUTE_LIM = 4'(MUTE_AFTER);

    bank_t      wr_bank_q;
    bank_t      rd_bank_q;
    logic       pending;
    logic       valid;
    logic [3:0] ur_run;
    logic [3:0] ur_next;
    logic       vld_p1;
    bank_t      rd_bank_p1;

    logic pending_eff;
    logic swap;
    logic starve;
    logic ovr_ev;
    logic udr_ev;

    assign rd_bank_q   = other_bank(wr_bank_q);
    assign pending_eff = pending | wr_frame_done;
    assign swap        = rd_frame_start & pending_eff;
    assign starve      = rd_frame_start & ~pending_eff;
    assign ovr_ev      = wr_frame_done & pending & ~rd_frame_start;
    // Replaying a bank before anything was ever delivered is start-up, not an underrun.
    assign udr_ev      = starve & valid;
    assign ur_next     = ur_run + 4'd1;

    assign buf0_wren = wr_en_in & (wr_bank_q == BANK0);
    assign buf1_wren = wr_en_in & (wr_bank_q == BANK1);
    assign buf0_rden = rd_en_in & (rd_bank_q == BANK0) & valid;
    assign buf1_rden = rd_en_in & (rd_bank_q == BANK1) & valid;

    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
    assign mute    = ~vld_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q  <= BANK0;
            pending    <= 1'b0;
            valid      <= 1'b0;
            ur_run     <= '0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
            vld_p1     <= 1'b0;
            rd_bank_p1 <= BANK1;
            dac_data   <= IDLE_CODE;
        end else begin
            overrun  <= ovr_ev;
            underrun <= udr_ev;
            if (swap) begin
                wr_bank_q <= other_bank(wr_bank_q);
                pending   <= 1'b0;
                valid     <= 1'b1;
                ur_run    <= '0;
            end else if (starve) begin
                if (ur_next == MUTE_LIM) begin
                    valid  <= 1'b0;
                    ur_run <= '0;
                end else begin
                    ur_run <= ur_next;
                end
            end else if (wr_frame_done) begin
                pending <= 1'b1;
            end
            // p1: RAM data returns for the read issued last cycle; mux on that cycle's bank.
            vld_p1     <= valid;
            rd_bank_p1 <= rd_bank_q;
            dac_data   <= (!vld_p1) ? IDLE_CODE : ((rd_bank_p1 == BANK1) ? buf1_q : buf0_q);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_ovr_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (ovr_ev),
        .cnt   (overrun_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_udr_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (udr_ev),
        .cnt   (underrun_cnt)
    );

endmodule

// File: tb/tb_skut_pingpong_ctrl.sv
// Self-checking bench for skut_pingpong_ctrl: directed vector table, hand sequences, random vs model.
module tb_skut_pingpong_ctrl;

    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int IDLE  = 8'h80;
    localparam int MA    = 4;
    localparam int CMAX  = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en_in = 1'b0, wr_frame_done = 1'b0, rd_frame_start = 1'b0, rd_en_in = 1'b0;
    logic [DW-1:0] buf0_q = '0, buf1_q = '0;
    logic          buf0_wren, buf1_wren, buf0_rden, buf1_rden, wr_bank, rd_bank, mute, overrun, underrun;
    logic [DW-1:0] dac_data;
    logic [CW-1:0] overrun_cnt, underrun_cnt;

    int total = 0;
    int bad   = 0;

    skut_pingpong_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_en_in(wr_en_in), .wr_frame_done(wr_frame_done),
        .rd_frame_start(rd_frame_start), .rd_en_in(rd_en_in),
        .buf0_q(buf0_q), .buf1_q(buf1_q),
        .buf0_wren(buf0_wren), .buf1_wren(buf1_wren),
        .buf0_rden(buf0_rden), .buf1_rden(buf1_rden),
        .wr_bank(wr_bank), .rd_bank(rd_bank),
        .dac_data(dac_data), .mute(mute),
        .overrun(overrun), .underrun(underrun),
        .overrun_cnt(overrun_cnt), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one frame slot waiting, a "delivering" flag, a starvation streak.
    int m_wbank, m_ready, m_live, m_streak, m_live_seen, m_bank_seen, m_dac, m_ov, m_un, m_oc, m_uc;

    task automatic model_reset();
        m_wbank = 0; m_ready = 0; m_live = 0; m_streak = 0;
        m_live_seen = 0; m_bank_seen = 1; m_dac = IDLE;
        m_ov = 0; m_un = 0; m_oc = 0; m_uc = 0;
    endtask

    task automatic model_step();
        int word;
        word = (m_live_seen == 0) ? IDLE : ((m_bank_seen == 1) ? int'(buf1_q) : int'(buf0_q));
        m_dac       = word;
        m_live_seen = m_live;
        m_bank_seen = 1 - m_wbank;
        m_ov = 0;
        m_un = 0;
        if (rd_frame_start) begin
            if (m_ready == 1 || wr_frame_done) begin
                m_wbank = 1 - m_wbank;
                m_ready = 0;
                m_live  = 1;
                m_streak = 0;
            end else begin
                if (m_live == 1) m_un = 1;
                m_streak++;
                if (m_streak == MA) begin
                    m_live = 0;
                    m_streak = 0;
                end
            end
        end else if (wr_frame_done) begin
            if (m_ready == 1) m_ov = 1;
            m_ready = 1;
        end
        if (m_ov == 1 && m_oc < CMAX) m_oc++;
        if (m_un == 1 && m_uc < CMAX) m_uc++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        int rb;
        rb = 1 - m_wbank;
        check("m_wr_bank", int'(wr_bank), m_wbank);
        check("m_rd_bank", int'(rd_bank), rb);
        check("m_buf0_wren", int'(buf0_wren), int'(wr_en_in) & int'(m_wbank == 0));
        check("m_buf1_wren", int'(buf1_wren), int'(wr_en_in) & int'(m_wbank == 1));
        check("m_buf0_rden", int'(buf0_rden), int'(rd_en_in) & int'(rb == 0) & m_live);
        check("m_buf1_rden", int'(buf1_rden), int'(rd_en_in) & int'(rb == 1) & m_live);
        check("m_mute", int'(mute), 1 - m_live_seen);
        check("m_dac", int'(dac_data), m_dac);
        check("m_overrun", int'(overrun), m_ov);
        check("m_underrun", int'(underrun), m_un);
        check("m_ovr_cnt", int'(overrun_cnt), m_oc);
        check("m_udr_cnt", int'(underrun_cnt), m_uc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_bank"}, int'(wr_bank), 0);
        check({tag, "_rd_bank"}, int'(rd_bank), 1);
        check({tag, "_mute"}, int'(mute), 1);
        check({tag, "_dac"}, int'(dac_data), IDLE);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_ovr_cnt"}, int'(overrun_cnt), 0);
        check({tag, "_udr_cnt"}, int'(underrun_cnt), 0);
        check({tag, "_enables"}, int'({buf0_wren, buf1_wren, buf0_rden, buf1_rden}), 0);
    endtask

    typedef struct {
        int rfs, wfd, wen, ren;
        int rb, mt, dac, ov, un, oc, uc;
    } vec_t;

    vec_t vec[19];

    initial begin
        // Inputs held during cycle k, expected outputs just after that cycle's edge.
        vec[0]  = '{1,0,0,0, 1,1,8'h80,0,0,0,0};
        vec[1]  = '{1,0,0,0, 1,1,8'h80,0,0,0,0};
        vec[2]  = '{1,0,0,0, 1,1,8'h80,0,0,0,0};
        vec[3]  = '{0,1,0,0, 1,1,8'h80,0,0,0,0};
        vec[4]  = '{1,0,0,0, 0,1,8'h80,0,0,0,0};
        vec[5]  = '{0,0,0,1, 0,0,8'h80,0,0,0,0};
        vec[6]  = '{0,0,0,0, 0,0,8'h3C,0,0,0,0};
        vec[7]  = '{0,1,0,0, 0,0,8'h3C,0,0,0,0};
        vec[8]  = '{0,1,0,0, 0,0,8'h3C,1,0,1,0};
        vec[9]  = '{0,0,0,0, 0,0,8'h3C,0,0,1,0};
        vec[10] = '{1,0,0,0, 1,0,8'h3C,0,0,1,0};
        vec[11] = '{1,1,0,0, 0,0,8'h3C,0,0,1,0};
        vec[12] = '{1,0,0,0, 0,0,8'h11,0,1,1,1};
        vec[13] = '{1,0,0,0, 0,0,8'h3C,0,1,1,2};
        vec[14] = '{1,0,0,0, 0,0,8'h3C,0,1,1,3};
        vec[15] = '{1,0,0,0, 0,0,8'h3C,0,1,1,4};
        vec[16] = '{0,0,0,0, 0,1,8'h3C,0,0,1,4};
        vec[17] = '{0,0,0,0, 0,1,8'h80,0,0,1,4};
        vec[18] = '{1,0,0,0, 0,1,8'h80,0,0,1,4};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;

        buf0_q = 8'h3C;
        buf1_q = 8'h11;
        for (int i = 0; i < 19; i++) begin
            rd_frame_start = vec[i].rfs[0];
            wr_frame_done  = vec[i].wfd[0];
            wr_en_in       = vec[i].wen[0];
            rd_en_in       = vec[i].ren[0];
            @(posedge clk);
            #1;
            if (i == 2) check("startup_rden", int'({buf0_rden, buf1_rden}), 0);
            if (i == 5) check("first_rden0", int'(buf0_rden), 1);
            check($sformatf("v%0d_rd_bank", i), int'(rd_bank), vec[i].rb);
            check($sformatf("v%0d_wr_bank", i), int'(wr_bank), 1 - vec[i].rb);
            check($sformatf("v%0d_mute", i), int'(mute), vec[i].mt);
            check($sformatf("v%0d_dac", i), int'(dac_data), vec[i].dac);
            check($sformatf("v%0d_overrun", i), int'(overrun), vec[i].ov);
            check($sformatf("v%0d_underrun", i), int'(underrun), vec[i].un);
            check($sformatf("v%0d_ovr_cnt", i), int'(overrun_cnt), vec[i].oc);
            check($sformatf("v%0d_udr_cnt", i), int'(underrun_cnt), vec[i].uc);
        end
        rd_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        rd_en_in       = 1'b0;

        // Overrun counter saturation: one frame fills the slot, 300 more each overrun it.
        wr_frame_done = 1'b1;
        repeat (301) @(posedge clk);
        #1;
        check("sat_ovr_cnt", int'(overrun_cnt), CMAX);
        check("sat_overrun_pulse", int'(overrun), 1);
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b1;
        @(posedge clk);
        #1;
        rd_frame_start = 1'b0;
        check("sat_swap_rd_bank", int'(rd_bank), 1);
        check("sat_overrun_clear", int'(overrun), 0);
        check("sat_ovr_hold", int'(overrun_cnt), CMAX);
        rd_en_in = 1'b1;
        @(posedge clk);
        #1;
        rd_en_in = 1'b0;
        check("pre_rst_mute", int'(mute), 0);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr_en_in = 1'b1;
        #1;
        check("post_rst_wren0", int'(buf0_wren), 1);
        check("post_rst_wren1", int'(buf1_wren), 0);
        wr_en_in = 1'b0;

        // Random traffic against the model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rd_frame_start = ($urandom_range(0, 7) == 0);
            wr_frame_done  = ($urandom_range(0, 5) == 0);
            wr_en_in       = 1'($urandom_range(0, 1));
            rd_en_in       = 1'($urandom_range(0, 1));
            buf0_q         = 8'($urandom);
            buf1_q         = 8'($urandom);
            step();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
